// File: rtl/tl_pkg.sv
// Shared definitions for the timed two-road phase scheduler.
// Contents: lamp encodings, FSM state codes (3-bit), next-direction type.
package tl_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_AG     = 3'd0,
    S_AY     = 3'd1,
    S_BG     = 3'd2,
    S_BY     = 3'd3,
    S_ALLRED = 3'd4,
    S_WALK   = 3'd5
  } state_t;

  // Road that receives green after the next all-red/walk interval.
  typedef enum logic {
    DIR_A = 1'b0,
    DIR_B = 1'b1
  } dir_t;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: counts cycles spent in the current phase.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset, clears the count
//   clear - synchronous clear, asserted on the cycle of a state change
//   cnt   - cycles elapsed in the phase, saturating at all-ones
module tl_phase_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tl_phase_scheduler.sv
// Timed phase scheduler for a two-road intersection with a latched
// pedestrian walk phase. Roads A/B cycle through green, yellow and
// all-red with minimum/maximum green times driven by sensors Ta/Tb.
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous active-high reset
//   Ta, Tb  - traffic present on road A / road B
//   ped_req - pedestrian button (level or pulse), sampled every cycle
//   La, Lb  - road A / road B lamp (00 green, 01 yellow, 10 red)
//   walk    - pedestrian walk lamp
//   phase   - current state code, for visibility
module tl_phase_scheduler
  import tl_pkg::*;
#(
  parameter int unsigned T_MIN_GREEN = 4,
  parameter int unsigned T_MAX_GREEN = 12,
  parameter int unsigned T_YELLOW    = 2,
  parameter int unsigned T_ALL_RED   = 1,
  parameter int unsigned T_WALK      = 5,
  parameter int unsigned CW          = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Ta,
  input  logic               Tb,
  input  logic               ped_req,
  output logic [1:0]         La,
  output logic [1:0]         Lb,
  output logic               walk,
  output logic [STATE_W-1:0] phase
);

  // Last count value of each timed interval.
  localparam logic [CW-1:0] MIN_LAST  = CW'(T_MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST  = CW'(T_MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_LAST  = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] AR_LAST   = CW'(T_ALL_RED - 1);
  localparam logic [CW-1:0] WALK_LAST = CW'(T_WALK - 1);

  state_t        state, state_nx;
  dir_t          next_dir, next_dir_nx;
  logic          ped_pend;
  logic          state_change;
  logic          walk_entry;
  logic [CW-1:0] cnt;

  tl_phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_change),
    .cnt   (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_AG;
      next_dir <= DIR_B;
    end else begin
      state    <= state_nx;
      next_dir <= next_dir_nx;
    end
  end

  // A new request arriving on the walk-entry cycle wins over the clear,
  // so it is served in the following round.
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_pend <= 1'b0;
    end else if (ped_req) begin
      ped_pend <= 1'b1;
    end else if (walk_entry) begin
      ped_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nx    = state;
    next_dir_nx = next_dir;
    case (state)
      S_AG: begin
        if (cnt >= MIN_LAST && (Tb || ped_pend) && (!Ta || cnt >= MAX_LAST)) begin
          state_nx = S_AY;
        end
      end
      S_AY: begin
        if (cnt == YEL_LAST) begin
          state_nx    = S_ALLRED;
          next_dir_nx = DIR_B;
        end
      end
      S_BG: begin
        if (cnt >= MIN_LAST && (Ta || ped_pend) && (!Tb || cnt >= MAX_LAST)) begin
          state_nx = S_BY;
        end
      end
      S_BY: begin
        if (cnt == YEL_LAST) begin
          state_nx    = S_ALLRED;
          next_dir_nx = DIR_A;
        end
      end
      S_ALLRED: begin
        if (cnt == AR_LAST) begin
          if (ped_pend) begin
            state_nx = S_WALK;
          end else if (next_dir == DIR_B) begin
            state_nx = S_BG;
          end else begin
            state_nx = S_AG;
          end
        end
      end
      S_WALK: begin
        if (cnt == WALK_LAST) begin
          if (next_dir == DIR_B) begin
            state_nx = S_BG;
          end else begin
            state_nx = S_AG;
          end
        end
      end
      default: begin
        state_nx    = S_ALLRED;
        next_dir_nx = DIR_A;
      end
    endcase
  end

  assign state_change = (state_nx != state);
  assign walk_entry   = (state_nx == S_WALK) && (state != S_WALK);

  always_comb begin
    La   = LAMP_RED;
    Lb   = LAMP_RED;
    walk = 1'b0;
    case (state)
      S_AG:    La   = LAMP_GREEN;
      S_AY:    La   = LAMP_YELLOW;
      S_BG:    Lb   = LAMP_GREEN;
      S_BY:    Lb   = LAMP_YELLOW;
      S_WALK:  walk = 1'b1;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Self-checking bench for tl_phase_scheduler: a fixed vector table for the
// post-reset sequence, hand-written multi-cycle corner cases, and a random
// run, all compared cycle by cycle against a phase/road reference model.
module tb_tl_phase_scheduler;

  localparam int MIN_G = 4;
  localparam int MAX_G = 12;
  localparam int YEL   = 2;
  localparam int AR    = 1;
  localparam int WLK   = 5;
  localparam int CMAX  = 15;

  logic       clk = 1'b0;
  logic       reset, Ta, Tb, ped_req;
  logic [1:0] La, Lb;
  logic       walk;
  logic [2:0] phase;

  int tests = 0;
  int fails = 0;

  // Reference model: kind 0=green 1=yellow 2=all-red 3=walk; road 0=A 1=B.
  int m_kind, m_road, m_t, m_next;
  bit m_ped;

  always #5 clk = ~clk;

  tl_phase_scheduler #(
    .T_MIN_GREEN(MIN_G),
    .T_MAX_GREEN(MAX_G),
    .T_YELLOW   (YEL),
    .T_ALL_RED  (AR),
    .T_WALK     (WLK),
    .CW         (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .Ta     (Ta),
    .Tb     (Tb),
    .ped_req(ped_req),
    .La     (La),
    .Lb     (Lb),
    .walk   (walk),
    .phase  (phase)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit ta, input bit tb, input bit pr);
    int nk, nr;
    bit own, other, went_walk;
    if (rst) begin
      m_kind = 0; m_road = 0; m_t = 0; m_ped = 0; m_next = 1;
      return;
    end
    own   = (m_road == 0) ? ta : tb;
    other = (m_road == 0) ? tb : ta;
    nk = m_kind; nr = m_road; went_walk = 0;
    case (m_kind)
      0: if (m_t >= MIN_G - 1 && (other || m_ped) && (!own || m_t >= MAX_G - 1)) nk = 1;
      1: if (m_t == YEL - 1) begin nk = 2; m_next = 1 - m_road; end
      2: if (m_t == AR - 1) begin
           if (m_ped) begin nk = 3; went_walk = 1; end
           else begin nk = 0; nr = m_next; end
         end
      default: if (m_t == WLK - 1) begin nk = 0; nr = m_next; end
    endcase
    if (pr) m_ped = 1;
    else if (went_walk) m_ped = 0;
    if (nk != m_kind || nr != m_road) m_t = 0;
    else m_t = (m_t < CMAX) ? m_t + 1 : CMAX;
    m_kind = nk; m_road = nr;
  endtask

  function automatic int lamp_of(input int road);
    if (m_road == road && m_kind == 0) return 0;
    if (m_road == road && m_kind == 1) return 1;
    return 2;
  endfunction

  function automatic int phase_of();
    if (m_kind < 2) return 2 * m_road + m_kind;
    return m_kind + 2;
  endfunction

  task automatic cycle(input bit rst, input bit ta, input bit tb, input bit pr);
    reset = rst; Ta = ta; Tb = tb; ped_req = pr;
    @(posedge clk);
    model_step(rst, ta, tb, pr);
    @(negedge clk);
    check("La", La, lamp_of(0));
    check("Lb", Lb, lamp_of(1));
    check("walk", walk, (m_kind == 3) ? 1 : 0);
    check("phase", phase, phase_of());
    check("cnt", dut.cnt, m_t);
  endtask

  typedef struct {
    bit         rst, ta, tb, pr;
    logic [7:0] exp; // {La, Lb, walk, phase}
  } vec_t;

  vec_t vt[11];

  initial begin
    int n, run, prev, walks, walk_n, after_walk, entries;
    bit pr, sa, sb;
    reset = 1'b1; Ta = 1'b0; Tb = 1'b1; ped_req = 1'b0;

    // Post-reset sequence: AG for 4 cycles, AY 2, ALLRED 1, then BG.
    vt[0]  = '{1, 0, 1, 0, {2'b00, 2'b10, 1'b0, 3'd0}};
    vt[1]  = '{1, 0, 1, 0, {2'b00, 2'b10, 1'b0, 3'd0}};
    vt[2]  = '{0, 0, 1, 0, {2'b00, 2'b10, 1'b0, 3'd0}};
    vt[3]  = '{0, 0, 1, 0, {2'b00, 2'b10, 1'b0, 3'd0}};
    vt[4]  = '{0, 0, 1, 0, {2'b00, 2'b10, 1'b0, 3'd0}};
    vt[5]  = '{0, 0, 1, 0, {2'b01, 2'b10, 1'b0, 3'd1}};
    vt[6]  = '{0, 0, 1, 0, {2'b01, 2'b10, 1'b0, 3'd1}};
    vt[7]  = '{0, 0, 1, 0, {2'b10, 2'b10, 1'b0, 3'd4}};
    vt[8]  = '{0, 0, 1, 0, {2'b10, 2'b00, 1'b0, 3'd2}};
    vt[9]  = '{0, 0, 1, 0, {2'b10, 2'b00, 1'b0, 3'd2}};
    vt[10] = '{0, 0, 1, 0, {2'b10, 2'b00, 1'b0, 3'd2}};
    for (int i = 0; i < 11; i++) begin
      cycle(vt[i].rst, vt[i].ta, vt[i].tb, vt[i].pr);
      check($sformatf("vec%0d", i), {La, Lb, walk, phase}, vt[i].exp);
    end

    // Both roads busy: every green lasts exactly MAX_G, no walk phase.
    cycle(1, 1, 1, 0);
    run = 1; prev = phase; walks = 0;
    for (int i = 0; i < 62; i++) begin
      cycle(0, 1, 1, 0);
      if (phase == 5) walks++;
      if (phase == prev) run++;
      else begin
        if (prev == 0 || prev == 2) check("green_len", run, MAX_G);
        run = 1;
      end
      prev = phase;
    end
    check("no_walk", walks, 0);

    // No demand: AG rests, counter saturates, then Tb moves to AY at once.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 50; i++) begin
      cycle(0, 0, 0, 0);
      check("rest_lamps", {La, Lb}, 4'b0010);
    end
    check("cnt_sat", dut.cnt, 15);
    cycle(0, 0, 1, 0);
    check("rest_to_AY", phase, 1);

    // Single pedestrian pulse in AG at cnt=1.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    walk_n = 0; after_walk = -1;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 0, 0, 0);
      if (walk) begin
        walk_n++;
        if (walk_n == 1) check("ped_clr", dut.ped_pend, 0);
        check("walk_lamps", {La, Lb}, 4'b1010);
      end else if (walk_n > 0 && after_walk < 0) after_walk = phase;
    end
    check("walk_len", walk_n, WLK);
    check("after_walk", after_walk, 2);

    // Request on the walk-entry cycle is re-latched: a second walk follows.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    entries = 0; prev = phase;
    for (int i = 0; i < 60; i++) begin
      pr = (phase == 4 && entries == 0);
      cycle(0, 0, 0, pr);
      if (phase == 5 && prev != 5) begin
        entries++;
        if (entries == 1) check("ped_relatch", dut.ped_pend, 1);
      end
      prev = phase;
    end
    check("walk_entries", entries, 2);

    // Reset pulse while in BY with cnt=1 and a pending request.
    cycle(1, 0, 1, 0);
    n = 0;
    while (phase != 2 && n < 30) begin cycle(0, 0, 1, 0); n++; end
    check("reach_BG", phase, 2);
    cycle(0, 1, 0, 1);
    n = 0;
    while (phase != 3 && n < 30) begin cycle(0, 1, 0, 0); n++; end
    check("reach_BY", phase, 3);
    cycle(0, 1, 0, 0);
    check("BY_cnt1", dut.cnt, 1);
    check("ped_before_rst", dut.ped_pend, 1);
    cycle(1, 1, 0, 0);
    check("rst_out", {La, Lb, walk, phase}, {2'b00, 2'b10, 1'b0, 3'd0});
    check("rst_ped", dut.ped_pend, 0);

    // Random traffic with sticky sensors, sparse buttons and rare resets.
    sa = 0; sb = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) sa = ~sa;
      if ($urandom_range(0, 7) == 0) sb = ~sb;
      cycle($urandom_range(0, 299) == 0, sa, sb, $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tl_phase_scheduler.md
Name: tl_phase_scheduler

Overview:
Timed phase scheduler for the two-road intersection. It sequences roads A and B through green, yellow and all-red phases with minimum and maximum green times, driven by the traffic sensors Ta and Tb. It adds a latched pedestrian-walk phase. It replaces the untimed sensor-only controller and drives the same La/Lb lamp buses.

Parameters:
T_MIN_GREEN, 4, minimum green cycles per road (>=1)
T_MAX_GREEN, 12, maximum green cycles while the other side has demand (>=T_MIN_GREEN)
T_YELLOW, 2, yellow cycles (>=1)
T_ALL_RED, 1, all-red clearance cycles (>=1)
T_WALK, 5, pedestrian walk cycles (>=1)
CW, 4, phase counter width; every T_* must be <= 2**CW

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
Ta  in  1  traffic present on road A
Tb  in  1  traffic present on road B
ped_req  in  1  pedestrian button, level or pulse, sampled every cycle
La  out  2  road A lamp
Lb  out  2  road B lamp
walk  out  1  pedestrian walk lamp
phase  out  3  current state encoding, for debug/visibility

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled on the rising clk edge and has priority over all other logic.
- Lamp encoding: GREEN=2'b00, YELLOW=2'b01, RED=2'b10. 2'b11 is never driven.
- States (encoding in 3 bits): AG=0, AY=1, BG=2, BY=3, ALLRED=4, WALK=5.
- Outputs are a Moore decode of the state register:
  - AG: La=G, Lb=R
  - AY: La=Y, Lb=R
  - BG: La=R, Lb=G
  - BY: La=R, Lb=Y
  - ALLRED: La=R, Lb=R
  - WALK: La=R, Lb=R, walk=1
  - walk=0 in every other state.
- Reset values: state=AG, cnt=0, ped_pend=0, next_dir=B. Outputs: La=G, Lb=R, walk=0, phase=0.
- Phase counter cnt:
  - Cleared to 0 on every state change.
  - Otherwise increments by 1 per cycle.
  - Saturates at 2**CW-1; it never wraps.
- Pedestrian latch ped_pend:
  - Set on any cycle with ped_req=1.
  - Cleared on the cycle the FSM enters WALK. If ped_req=1 on that same cycle, set wins and the request is re-latched for the next cycle.
  - A request during WALK is therefore served in the next round.
- Demand definitions:
  - dem_other (in AG) = Tb | ped_pend
  - dem_other (in BG) = Ta | ped_pend
- AG -> AY when cnt>=T_MIN_GREEN-1 AND dem_other AND (Ta==0 OR cnt>=T_MAX_GREEN-1). Otherwise stay in AG; with no demand anywhere, AG rests indefinitely. BG -> BY is symmetric with Ta/Tb swapped.
- AY -> ALLRED when cnt==T_YELLOW-1, setting next_dir=B. BY -> ALLRED is symmetric, setting next_dir=A.
- ALLRED exit at cnt==T_ALL_RED-1:
  - if ped_pend: -> WALK
  - else if next_dir=B: -> BG
  - else: -> AG
- WALK -> next_dir green (AG or BG) when cnt==T_WALK-1.
- Latency: a sensor change affects the next-state decision in the same cycle; the lamps change on the following edge. Min gap between the two greens = T_YELLOW+T_ALL_RED cycles.
- Reset mid-phase: next edge forces AG/reset values, and any pending pedestrian request is dropped.
- Illegal state codes 6/7 recover to ALLRED with next_dir=A.

Decomposition:
- Package tl_pkg holds:
  - lamp constants LAMP_GREEN/LAMP_YELLOW/LAMP_RED
  - state codes S_AG..S_WALK
  - the 3-bit state width constant
- One sub-module, tl_phase_timer (CW-bit counter with sync clear and saturation, output cnt), instantiated once.
- The FSM, pedestrian latch and output decode live in tl_phase_scheduler.

Test Plan:
- Reset held 2 cycles, then released with Ta=0, Tb=1 (defaults) -> La=00 for exactly 4 cycles, 01 for 2, then 10 with Lb=10 for 1 cycle. Lb=00 on the 8th cycle after release.
- Ta=1, Tb=1 held continuously -> each green lasts exactly 12 cycles. The cycle pattern G12/Y2/R1 alternates A/B indefinitely and phase never equals 5.
- Ta=0, Tb=0, no ped_req -> La=00, Lb=10 stable for 50 cycles and cnt saturates at 15 without wrap. Then Tb=1 -> AY on the next edge.
- Single-cycle ped_req pulse during AG (cnt=1), Ta=0 -> AY after cnt=3, then ALLRED, then walk=1 with La=Lb=10 for 5 cycles, then BG. ped_pend=0 after WALK entry.
- ped_req=1 asserted on the WALK-entry cycle -> ped_pend re-latched. The following ALLRED goes to WALK again instead of green.
- reset pulsed for 1 cycle while in BY with cnt=1 -> next edge gives La=00, Lb=10, walk=0, phase=0, ped_pend=0.
